// File: rtl/alu_reservation_station_if.sv
// Issue bus from the issue stage into the ALU reservation station.
// The issuer is the master and the station is the slave, which reports back rs_full.
interface alu_reservation_station_if #(
   parameter int unsigned ROB_POS_W = 4
);
   logic                 issue;
   logic [6:0]           issue_opcode;
   logic [2:0]           issue_funct3;
   logic                 issue_funct7;
   logic [31:0]          issue_rs1_val;
   logic                 issue_rs1_dep;
   logic [ROB_POS_W-1:0] issue_rs1_tag;
   logic [31:0]          issue_rs2_val;
   logic                 issue_rs2_dep;
   logic [ROB_POS_W-1:0] issue_rs2_tag;
   logic [31:0]          issue_imm;
   logic [31:0]          issue_pc;
   logic [ROB_POS_W-1:0] issue_rob_pos;
   logic                 rs_full;

   modport master (
      output issue, issue_opcode, issue_funct3, issue_funct7,
             issue_rs1_val, issue_rs1_dep, issue_rs1_tag,
             issue_rs2_val, issue_rs2_dep, issue_rs2_tag,
             issue_imm, issue_pc, issue_rob_pos,
      input  rs_full
   );

   modport slave (
      input  issue, issue_opcode, issue_funct3, issue_funct7,
             issue_rs1_val, issue_rs1_dep, issue_rs1_tag,
             issue_rs2_val, issue_rs2_dep, issue_rs2_tag,
             issue_imm, issue_pc, issue_rob_pos,
      output rs_full
   );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers ALU-class instructions until both operands are
// available, snooping ALU/LSB broadcasts, and dispatches one ready entry per cycle.
module alu_reservation_station #(
   parameter int unsigned RS_SIZE   = 16,
   parameter int unsigned RS_IDX_W  = 4,
   parameter int unsigned ROB_POS_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     rollback,
   alu_reservation_station_if.slave iss,
   input  logic                     alu_result,
   input  logic [ROB_POS_W-1:0]     alu_result_rob_pos,
   input  logic [31:0]              alu_result_val,
   input  logic                     lsb_result,
   input  logic [ROB_POS_W-1:0]     lsb_result_rob_pos,
   input  logic [31:0]              lsb_result_val,
   output logic                     alu_en,
   output logic [6:0]               alu_opcode,
   output logic [2:0]               alu_funct3,
   output logic                     alu_funct7,
   output logic [31:0]              alu_val1,
   output logic [31:0]              alu_val2,
   output logic [31:0]              alu_imm,
   output logic [31:0]              alu_pc,
   output logic [ROB_POS_W-1:0]     alu_rob_pos
);

   logic [RS_SIZE-1:0]   busy;
   logic [6:0]           opcode  [RS_SIZE];
   logic [2:0]           funct3  [RS_SIZE];
   logic                 funct7  [RS_SIZE];
   logic [31:0]          val1    [RS_SIZE];
   logic                 dep1    [RS_SIZE];
   logic [ROB_POS_W-1:0] tag1    [RS_SIZE];
   logic [31:0]          val2    [RS_SIZE];
   logic                 dep2    [RS_SIZE];
   logic [ROB_POS_W-1:0] tag2    [RS_SIZE];
   logic [31:0]          imm     [RS_SIZE];
   logic [31:0]          pc      [RS_SIZE];
   logic [ROB_POS_W-1:0] rob_pos [RS_SIZE];

   logic                 full;
   logic                 free_found, sel_found;
   logic [RS_IDX_W-1:0]  free_idx, sel_idx;
   logic [31:0]          new_val1, new_val2;
   logic                 new_dep1, new_dep2;

   assign full        = &busy;
   assign iss.rs_full = full;

   // Both priority encoders look at pre-edge state only, so a freshly issued or
   // freshly woken entry is never selected in the same cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!busy[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = RS_IDX_W'(i);
         end
         if (busy[i] && !dep1[i] && !dep2[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = RS_IDX_W'(i);
         end
      end
   end

   // Same-cycle bypass for operands of the instruction being issued; ALU wins a tie.
   always_comb begin
      new_val1 = iss.issue_rs1_val;
      new_dep1 = iss.issue_rs1_dep;
      new_val2 = iss.issue_rs2_val;
      new_dep2 = iss.issue_rs2_dep;
      if (iss.issue_rs1_dep) begin
         if (alu_result && alu_result_rob_pos == iss.issue_rs1_tag) begin
            new_val1 = alu_result_val;
            new_dep1 = 1'b0;
         end else if (lsb_result && lsb_result_rob_pos == iss.issue_rs1_tag) begin
            new_val1 = lsb_result_val;
            new_dep1 = 1'b0;
         end
      end
      if (iss.issue_rs2_dep) begin
         if (alu_result && alu_result_rob_pos == iss.issue_rs2_tag) begin
            new_val2 = alu_result_val;
            new_dep2 = 1'b0;
         end else if (lsb_result && lsb_result_rob_pos == iss.issue_rs2_tag) begin
            new_val2 = lsb_result_val;
            new_dep2 = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || rollback) begin
         busy        <= '0;
         alu_en      <= 1'b0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= 1'b0;
         alu_val1    <= '0;
         alu_val2    <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rob_pos <= '0;
      end else if (rdy) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && dep1[i]) begin
               if (alu_result && alu_result_rob_pos == tag1[i]) begin
                  val1[i] <= alu_result_val;
                  dep1[i] <= 1'b0;
               end else if (lsb_result && lsb_result_rob_pos == tag1[i]) begin
                  val1[i] <= lsb_result_val;
                  dep1[i] <= 1'b0;
               end
            end
            if (busy[i] && dep2[i]) begin
               if (alu_result && alu_result_rob_pos == tag2[i]) begin
                  val2[i] <= alu_result_val;
                  dep2[i] <= 1'b0;
               end else if (lsb_result && lsb_result_rob_pos == tag2[i]) begin
                  val2[i] <= lsb_result_val;
                  dep2[i] <= 1'b0;
               end
            end
         end

         if (sel_found) begin
            alu_en         <= 1'b1;
            alu_opcode     <= opcode[sel_idx];
            alu_funct3     <= funct3[sel_idx];
            alu_funct7     <= funct7[sel_idx];
            alu_val1       <= val1[sel_idx];
            alu_val2       <= val2[sel_idx];
            alu_imm        <= imm[sel_idx];
            alu_pc         <= pc[sel_idx];
            alu_rob_pos    <= rob_pos[sel_idx];
            busy[sel_idx]  <= 1'b0;
         end else begin
            alu_en <= 1'b0;
         end

         // The issue slot is non-busy and the dispatch slot is busy, so they never collide.
         if (iss.issue && !full) begin
            busy[free_idx]    <= 1'b1;
            opcode[free_idx]  <= iss.issue_opcode;
            funct3[free_idx]  <= iss.issue_funct3;
            funct7[free_idx]  <= iss.issue_funct7;
            val1[free_idx]    <= new_val1;
            dep1[free_idx]    <= new_dep1;
            tag1[free_idx]    <= iss.issue_rs1_tag;
            val2[free_idx]    <= new_val2;
            dep2[free_idx]    <= new_dep2;
            tag2[free_idx]    <= iss.issue_rs2_tag;
            imm[free_idx]     <= iss.issue_imm;
            pc[free_idx]      <= iss.issue_pc;
            rob_pos[free_idx] <= iss.issue_rob_pos;
         end
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a vector table of single issues
// plus hand-written sequences for wakeup, fill, full, rdy freeze and rollback.
module tb_alu_reservation_station;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback;
   logic        alu_result, lsb_result;
   logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
   logic [31:0] alu_result_val, lsb_result_val;
   logic        alu_en;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic        alu_funct7;
   logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
   logic [3:0]  alu_rob_pos;

   int passed = 0;
   int total  = 0;

   alu_reservation_station_if #(.ROB_POS_W(4)) iss ();

   alu_reservation_station #(.RS_SIZE(16), .RS_IDX_W(4), .ROB_POS_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .iss(iss),
      .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
      .alu_result_val(alu_result_val),
      .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
      .lsb_result_val(lsb_result_val),
      .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
      .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
      .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;  logic [2:0] f3; logic f7;
      logic [31:0] v1;  logic d1; logic [3:0] t1;
      logic [31:0] v2;  logic d2; logic [3:0] t2;
      logic [31:0] imm; logic [31:0] pc; logic [3:0] rob;
      logic        ab;  logic [3:0] at; logic [31:0] av;
      logic        lb;  logic [3:0] lt; logic [31:0] lv;
      logic [31:0] e1;  logic [31:0] e2;
   } vec_t;

   function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic f7,
         logic [31:0] v1, logic d1, logic [3:0] t1,
         logic [31:0] v2, logic d2, logic [3:0] t2,
         logic [31:0] imm, logic [31:0] pc, logic [3:0] rob,
         logic ab, logic [3:0] at, logic [31:0] av,
         logic lb, logic [3:0] lt, logic [31:0] lv,
         logic [31:0] e1, logic [31:0] e2);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7;
      v.v1 = v1; v.d1 = d1; v.t1 = t1;
      v.v2 = v2; v.d2 = d2; v.t2 = t2;
      v.imm = imm; v.pc = pc; v.rob = rob;
      v.ab = ab; v.at = at; v.av = av;
      v.lb = lb; v.lt = lt; v.lv = lv;
      v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_bus();
      iss.issue = 1'b0;
      iss.issue_opcode = '0; iss.issue_funct3 = '0; iss.issue_funct7 = 1'b0;
      iss.issue_rs1_val = '0; iss.issue_rs1_dep = 1'b0; iss.issue_rs1_tag = '0;
      iss.issue_rs2_val = '0; iss.issue_rs2_dep = 1'b0; iss.issue_rs2_tag = '0;
      iss.issue_imm = '0; iss.issue_pc = '0; iss.issue_rob_pos = '0;
      alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
      lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
   endtask

   task automatic drive_issue(input logic [31:0] v1, input logic d1, input logic [3:0] t1,
                              input logic [31:0] v2, input logic d2, input logic [3:0] t2,
                              input logic [3:0] rob);
      iss.issue = 1'b1;
      iss.issue_opcode = 7'b0110011;
      iss.issue_funct3 = 3'd0; iss.issue_funct7 = 1'b0;
      iss.issue_rs1_val = v1; iss.issue_rs1_dep = d1; iss.issue_rs1_tag = t1;
      iss.issue_rs2_val = v2; iss.issue_rs2_dep = d2; iss.issue_rs2_tag = t2;
      iss.issue_imm = 32'h0; iss.issue_pc = 32'h0; iss.issue_rob_pos = rob;
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = mk(7'b0110011, 3'd0, 1'b0, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0,
                   32'h0, 32'h0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'd5, 32'd7);
      vecs[1] = mk(7'b0110011, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0,
                   32'h0, 32'h100, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'hFFFF_FFFF, 32'd1);
      vecs[2] = mk(7'b0010011, 3'd7, 1'b0, 32'd9, 1'b0, 4'd0, 32'h1234, 1'b1, 4'd2,
                   32'h7FF, 32'h104, 4'd4, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h40, 32'd9, 32'h40);
      vecs[3] = mk(7'b1100011, 3'd1, 1'b0, 32'h0, 1'b1, 4'd5, 32'd3, 1'b0, 4'd0,
                   32'hFFFF_FFF0, 32'h200, 4'd6, 1'b1, 4'd5, 32'hCAFE, 1'b0, 4'd0, 32'h0, 32'hCAFE, 32'd3);
      vecs[4] = mk(7'b1101111, 3'd0, 1'b0, 32'h0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0,
                   32'h8, 32'h300, 4'd7, 1'b1, 4'd7, 32'h11, 1'b1, 4'd7, 32'h22, 32'h11, 32'd0);
      vecs[5] = mk(7'b1100111, 3'd0, 1'b0, 32'hA5A5, 1'b0, 4'd4, 32'd2, 1'b0, 4'd4,
                   32'h4, 32'h400, 4'd9, 1'b1, 4'd4, 32'h99, 1'b1, 4'd4, 32'h98, 32'hA5A5, 32'd2);
      vecs[6] = mk(7'b0110111, 3'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'hABCD_E000, 32'h2000, 4'd8, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
      clear_bus();
      tick(); tick();
      rst = 1'b0;

      chk("reset_alu_en", {31'b0, alu_en}, 32'd0);
      chk("reset_rs_full", {31'b0, iss.rs_full}, 32'd0);
      chk("reset_opcode", {25'b0, alu_opcode}, 32'd0);
      chk("reset_val1", alu_val1, 32'd0);
      chk("reset_val2", alu_val2, 32'd0);
      chk("reset_imm", alu_imm, 32'd0);
      chk("reset_pc", alu_pc, 32'd0);
      chk("reset_rob", {28'b0, alu_rob_pos}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_alu_en", {31'b0, alu_en}, 32'd0);
      end

      // Table: issue one instruction, expect dispatch two edges later and nothing after.
      for (int k = 0; k < 7; k++) begin
         iss.issue = 1'b1;
         iss.issue_opcode = vecs[k].op; iss.issue_funct3 = vecs[k].f3; iss.issue_funct7 = vecs[k].f7;
         iss.issue_rs1_val = vecs[k].v1; iss.issue_rs1_dep = vecs[k].d1; iss.issue_rs1_tag = vecs[k].t1;
         iss.issue_rs2_val = vecs[k].v2; iss.issue_rs2_dep = vecs[k].d2; iss.issue_rs2_tag = vecs[k].t2;
         iss.issue_imm = vecs[k].imm; iss.issue_pc = vecs[k].pc; iss.issue_rob_pos = vecs[k].rob;
         alu_result = vecs[k].ab; alu_result_rob_pos = vecs[k].at; alu_result_val = vecs[k].av;
         lsb_result = vecs[k].lb; lsb_result_rob_pos = vecs[k].lt; lsb_result_val = vecs[k].lv;
         tick();
         clear_bus();
         chk("vec_not_early", {31'b0, alu_en}, 32'd0);
         tick();
         chk("vec_alu_en", {31'b0, alu_en}, 32'd1);
         chk("vec_opcode", {25'b0, alu_opcode}, {25'b0, vecs[k].op});
         chk("vec_funct3", {29'b0, alu_funct3}, {29'b0, vecs[k].f3});
         chk("vec_funct7", {31'b0, alu_funct7}, {31'b0, vecs[k].f7});
         chk("vec_val1", alu_val1, vecs[k].e1);
         chk("vec_val2", alu_val2, vecs[k].e2);
         chk("vec_imm", alu_imm, vecs[k].imm);
         chk("vec_pc", alu_pc, vecs[k].pc);
         chk("vec_rob", {28'b0, alu_rob_pos}, {28'b0, vecs[k].rob});
         tick();
         chk("vec_alu_en_off", {31'b0, alu_en}, 32'd0);
         chk("vec_rob_hold", {28'b0, alu_rob_pos}, {28'b0, vecs[k].rob});
      end

      // Wakeup from a later ALU broadcast.
      drive_issue(32'h0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 4'd1);
      tick();
      clear_bus();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wake_wait", {31'b0, alu_en}, 32'd0);
      end
      alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'hDEAD;
      tick();
      clear_bus();
      chk("wake_not_same", {31'b0, alu_en}, 32'd0);
      tick();
      chk("wake_alu_en", {31'b0, alu_en}, 32'd1);
      chk("wake_val1", alu_val1, 32'hDEAD);
      chk("wake_rob", {28'b0, alu_rob_pos}, 32'd1);
      tick();
      chk("wake_off", {31'b0, alu_en}, 32'd0);

      // Back-to-back ready issues drain one per cycle, in order, never filling.
      for (int i = 0; i < 16; i++) begin
         chk("stream_not_full", {31'b0, iss.rs_full}, 32'd0);
         drive_issue(32'(i), 1'b0, 4'd0, 32'(i + 100), 1'b0, 4'd0, 4'(i));
         tick();
         if (i > 0) begin
            chk("stream_alu_en", {31'b0, alu_en}, 32'd1);
            chk("stream_rob", {28'b0, alu_rob_pos}, 32'(i - 1));
            chk("stream_val2", alu_val2, 32'(i + 99));
         end
      end
      clear_bus();
      tick();
      chk("stream_last_rob", {28'b0, alu_rob_pos}, 32'd15);
      tick();
      chk("stream_done", {31'b0, alu_en}, 32'd0);

      // Fill with entries blocked on tag 9, drop a 17th, then wake all.
      for (int i = 0; i < 16; i++) begin
         drive_issue(32'h0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(i));
         tick();
      end
      clear_bus();
      chk("full_set", {31'b0, iss.rs_full}, 32'd1);
      chk("full_no_dispatch", {31'b0, alu_en}, 32'd0);
      drive_issue(32'h55, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 4'd5);
      tick();
      clear_bus();
      chk("full_hold", {31'b0, iss.rs_full}, 32'd1);
      alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h77;
      tick();
      clear_bus();
      chk("full_wake_not_same", {31'b0, alu_en}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("drain_alu_en", {31'b0, alu_en}, 32'd1);
         chk("drain_rob", {28'b0, alu_rob_pos}, 32'(i));
         chk("drain_val1", alu_val1, 32'h77);
         chk("drain_val2", alu_val2, 32'(i));
      end
      tick();
      chk("drain_done", {31'b0, alu_en}, 32'd0);
      chk("drain_not_full", {31'b0, iss.rs_full}, 32'd0);

      // rdy low freezes dispatch, holds alu_en, and ignores issue.
      drive_issue(32'd2, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 4'd2);
      tick();
      clear_bus();
      rdy = 1'b0;
      tick();
      chk("frz_no_dispatch", {31'b0, alu_en}, 32'd0);
      tick();
      chk("frz_no_dispatch2", {31'b0, alu_en}, 32'd0);
      rdy = 1'b1;
      tick();
      chk("frz_dispatch", {31'b0, alu_en}, 32'd1);
      chk("frz_rob", {28'b0, alu_rob_pos}, 32'd2);
      rdy = 1'b0;
      drive_issue(32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 4'd9);
      tick();
      chk("frz_hold_en", {31'b0, alu_en}, 32'd1);
      clear_bus();
      rdy = 1'b1;
      tick();
      chk("frz_en_drop", {31'b0, alu_en}, 32'd0);
      tick();
      chk("frz_issue_ignored", {31'b0, alu_en}, 32'd0);

      // Rollback with four blocked entries and a dispatch in flight.
      for (int i = 1; i <= 4; i++) begin
         drive_issue(32'h0, 1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 4'(i));
         tick();
      end
      drive_issue(32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd7);
      tick();
      clear_bus();
      tick();
      chk("rb_pre_en", {31'b0, alu_en}, 32'd1);
      chk("rb_pre_rob", {28'b0, alu_rob_pos}, 32'd7);
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      chk("rb_alu_en", {31'b0, alu_en}, 32'd0);
      chk("rb_rs_full", {31'b0, iss.rs_full}, 32'd0);
      chk("rb_rob_clr", {28'b0, alu_rob_pos}, 32'd0);
      chk("rb_val1_clr", alu_val1, 32'd0);
      alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'hBEEF;
      tick();
      clear_bus();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rb_no_dispatch", {31'b0, alu_en}, 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Holds decoded ALU-class instructions (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC) until their operands are available, then feeds them one per cycle to the ALU execution unit.
- Sits between the issue stage and the ALU.
- Snoops the ALU and LSB result broadcasts to wake up waiting operands.
- Flushes completely on rollback.

Parameters:
RS_SIZE, 16, number of entries (power of two, ≥2)
RS_IDX_W, 4, log2(RS_SIZE)
ROB_POS_W, 4, width of ROB tags (matches `ROB_POS_WID)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
rollback  in  1  flush all entries
rs_full  out  1  combinational; high when no free entry
issue  in  1  issue valid; write new entry
issue_opcode  in  7  opcode
issue_funct3  in  3  funct3
issue_funct7  in  1  funct7 bit 30
issue_rs1_val  in  32  operand 1 value, valid when issue_rs1_dep=0
issue_rs1_dep  in  1  operand 1 waits on ROB tag
issue_rs1_tag  in  ROB_POS_W  producer tag for operand 1
issue_rs2_val / issue_rs2_dep / issue_rs2_tag  in  32/1/ROB_POS_W  same, operand 2
issue_imm  in  32  immediate
issue_pc  in  32  instruction PC
issue_rob_pos  in  ROB_POS_W  destination ROB tag
alu_result  in  1  ALU broadcast valid
alu_result_rob_pos  in  ROB_POS_W  ALU broadcast tag
alu_result_val  in  32  ALU broadcast value
lsb_result  in  1  LSB broadcast valid
lsb_result_rob_pos  in  ROB_POS_W  LSB broadcast tag
lsb_result_val  in  32  LSB broadcast value
alu_en  out  1  dispatch valid to ALU (registered)
alu_opcode / alu_funct3 / alu_funct7  out  7/3/1  dispatched fields (registered)
alu_val1 / alu_val2 / alu_imm / alu_pc  out  32 each  dispatched operands (registered)
alu_rob_pos  out  ROB_POS_W  dispatched tag (registered)

Behaviour:
- Reset and rollback (same priority, checked before rdy): all entry busy bits cleared; alu_en=0; every other registered output=0. Entry payloads need not be cleared.
- rdy=0: no state changes; issue and broadcasts in that cycle are ignored. alu_en holds its value; the ALU is frozen by the same rdy.
- Entry state: busy, opcode, funct3, funct7, val1, dep1, tag1, val2, dep2, tag2, imm, pc, rob_pos.
- Ready entry: busy && !dep1 && !dep2.
- rs_full = all busy bits set.
  - Computed from registered state only.
  - Issuer must not assert issue while rs_full=1; issue while full is dropped with no state change.
- Issue: writes the lowest-index non-busy entry, sets busy.
  - Same-cycle bypass: if issue_rsX_dep=1 and (alu_result && alu_result_rob_pos==issue_rsX_tag), store alu_result_val with depX=0. Same rule for lsb_result.
  - If both broadcasts match, ALU value wins; this cannot legally happen.
- Wakeup: each cycle, every busy entry with depX=1 and tagX matching a valid broadcast captures the value and clears depX. The entry may be dispatched starting the next cycle.
- Dispatch select: among ready entries (registered state), choose the lowest index.
  - On the next edge: alu_en=1, output fields loaded from that entry, entry busy cleared.
  - No ready entry: alu_en=0; other outputs hold.
  - Throughput 1/cycle.
  - Minimum latency from issue (operands ready) to alu_en high is 2 edges: the write edge, then the dispatch edge.
- Simultaneous issue + dispatch in one cycle:
  - Both allowed.
  - Issue slot is chosen from pre-edge busy bits, so the slot being freed by dispatch is not reused in that cycle.
  - A just-issued entry is never dispatched in the same cycle.
- Wakeup and dispatch of the same entry in the same cycle cannot occur, because select uses pre-wakeup deps.
- Opcode is not interpreted; all fields pass through unchanged.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> alu_en=0, rs_full=0, all outputs 0; no dispatch for 10 idle cycles.
- Ready issue: issue ADD with rs1_val=5, rs2_val=7, rob_pos=3 at cycle T -> alu_en=1 at T+2 with alu_val1=5, alu_val2=7, alu_rob_pos=3; alu_en=0 at T+3.
- Wakeup: issue with rs1_dep=1, rs1_tag=6; hold for 3 cycles, then alu_result=1, tag 6, val 0xDEAD at cycle U -> dispatch alu_en=1 at U+2 with alu_val1=0xDEAD.
- Same-cycle bypass: issue with rs2_dep=1, tag 2, while lsb_result=1, tag 2, val 0x40 -> entry ready immediately; dispatch at T+2 with alu_val2=0x40.
- Fill/order: issue 16 ready entries with rob_pos 0..15 back-to-back -> rs_full never blocks, since dispatch drains one per cycle; dispatch order matches lowest index. Separately, with all entries blocked on tag 9, 16 issues -> rs_full=1, and a 17th issue is dropped.
- Rollback mid-stream: 4 busy entries, alu_en=1, assert rollback -> next cycle alu_en=0, rs_full=0; earlier entries are never dispatched, even when broadcasts matching their tags arrive afterwards.
